axi4_rd_arbiter: RTL and testbench

AXI4_RD_ARBITER -- requirements
Module: axi4_rd_arbiter

---
 rtl/axi4_rd_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_axi4_rd_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_rd_arbiter.sv
// Two-master AXI4 read arbiter with a single outstanding transaction.
// The AR request is registered, and the R channel is steered back to the granted master.
module axi4_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,

  input  logic [ADDR_WIDTH-1:0] S0_ARADDR,
  input  logic [7:0]            S0_ARLEN,
  input  logic [ID_WIDTH-1:0]   S0_ARID,
  input  logic                  S0_ARVALID,
  output logic                  S0_ARREADY,
  output logic [DATA_WIDTH-1:0] S0_RDATA,
  output logic [ID_WIDTH-1:0]   S0_RID,
  output logic [1:0]            S0_RRESP,
  output logic                  S0_RLAST,
  output logic                  S0_RVALID,
  input  logic                  S0_RREADY,

  input  logic [ADDR_WIDTH-1:0] S1_ARADDR,
  input  logic [7:0]            S1_ARLEN,
  input  logic [ID_WIDTH-1:0]   S1_ARID,
  input  logic                  S1_ARVALID,
  output logic                  S1_ARREADY,
  output logic [DATA_WIDTH-1:0] S1_RDATA,
  output logic [ID_WIDTH-1:0]   S1_RID,
  output logic [1:0]            S1_RRESP,
  output logic                  S1_RLAST,
  output logic                  S1_RVALID,
  input  logic                  S1_RREADY,

  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [7:0]            M_ARLEN,
  output logic [ID_WIDTH-1:0]   M_ARID,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [ID_WIDTH-1:0]   M_RID,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,

  output logic                  GRANT,
  output logic                  PROTO_ERR
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    lastGrant_q, lastGrant_d;
  logic                    grant_q, grant_d;
  logic                    protoErr_q, protoErr_d;
  logic [7:0]              beatCnt_q, beatCnt_d;
  logic [ADDR_WIDTH-1:0]   arAddr_q, arAddr_d;
  logic [7:0]              arLen_q, arLen_d;
  logic [ID_WIDTH-1:0]     arId_q, arId_d;

  logic                    anyReq;
  logic                    winner;
  logic                    selRready;
  logic                    rHandshake;

  // On a tie the master that did not win last time is chosen.
  always_comb begin
    anyReq = S0_ARVALID | S1_ARVALID;
    if (S0_ARVALID && S1_ARVALID) begin
      winner = ~lastGrant_q;
    end else begin
      winner = S1_ARVALID;
    end
  end

  assign selRready  = grant_q ? S1_RREADY : S0_RREADY;
  assign rHandshake = (state_q == DATA) && M_RVALID && selRready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      grant_q     <= 1'b0;
      protoErr_q  <= 1'b0;
      beatCnt_q   <= '0;
      arAddr_q    <= '0;
      arLen_q     <= '0;
      arId_q      <= '0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grant_q     <= grant_d;
      protoErr_q  <= protoErr_d;
      beatCnt_q   <= beatCnt_d;
      arAddr_q    <= arAddr_d;
      arLen_q     <= arLen_d;
      arId_q      <= arId_d;
    end
  end

  // Handshake outputs are qualified by ARESETN so they drop during reset.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    grant_d     = grant_q;
    protoErr_d  = protoErr_q;
    beatCnt_d   = beatCnt_q;
    arAddr_d    = arAddr_q;
    arLen_d     = arLen_q;
    arId_d      = arId_q;
    S0_ARREADY  = 1'b0;
    S1_ARREADY  = 1'b0;
    M_ARVALID   = 1'b0;
    M_RREADY    = 1'b0;
    S0_RVALID   = 1'b0;
    S1_RVALID   = 1'b0;
    S0_RLAST    = 1'b0;
    S1_RLAST    = 1'b0;

    if (ARESETN) begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            S0_ARREADY = ~winner;
            S1_ARREADY = winner;
            grant_d    = winner;
            arAddr_d   = winner ? S1_ARADDR : S0_ARADDR;
            arLen_d    = winner ? S1_ARLEN  : S0_ARLEN;
            arId_d     = winner ? S1_ARID   : S0_ARID;
            state_d    = ADDR;
          end
        end

        ADDR: begin
          M_ARVALID = 1'b1;
          if (M_ARREADY) begin
            beatCnt_d = '0;
            state_d   = DATA;
          end
        end

        DATA: begin
          M_RREADY  = selRready;
          S0_RVALID = ~grant_q & M_RVALID;
          S1_RVALID = grant_q & M_RVALID;
          S0_RLAST  = ~grant_q & M_RLAST;
          S1_RLAST  = grant_q & M_RLAST;
          // Only RLAST ends the burst; a length mismatch just raises the sticky flag.
          if (rHandshake) begin
            beatCnt_d = beatCnt_q + 8'd1;
            if (M_RLAST) begin
              if (beatCnt_q != arLen_q) begin
                protoErr_d = 1'b1;
              end
              lastGrant_d = grant_q;
              state_d     = IDLE;
            end else if (beatCnt_q == arLen_q) begin
              protoErr_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign M_ARADDR  = arAddr_q;
  assign M_ARLEN   = arLen_q;
  assign M_ARID    = arId_q;

  assign S0_RDATA  = M_RDATA;
  assign S0_RID    = M_RID;
  assign S0_RRESP  = M_RRESP;
  assign S1_RDATA  = M_RDATA;
  assign S1_RID    = M_RID;
  assign S1_RRESP  = M_RRESP;

  assign GRANT     = grant_q;
  assign PROTO_ERR = protoErr_q;

endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Directed bench for axi4_rd_arbiter: arbitration order, AR stalls, R steering,
// protocol-error flag and mid-burst reset.
module tb_axi4_rd_arbiter;

  logic        ACLK;
  logic        ARESETN;
  logic [31:0] S0_ARADDR, S1_ARADDR, M_ARADDR;
  logic [7:0]  S0_ARLEN, S1_ARLEN, M_ARLEN;
  logic [3:0]  S0_ARID, S1_ARID, M_ARID;
  logic        S0_ARVALID, S1_ARVALID, M_ARVALID;
  logic        S0_ARREADY, S1_ARREADY, M_ARREADY;
  logic [31:0] M_RDATA, S0_RDATA, S1_RDATA;
  logic [3:0]  M_RID, S0_RID, S1_RID;
  logic [1:0]  M_RRESP, S0_RRESP, S1_RRESP;
  logic        M_RLAST, S0_RLAST, S1_RLAST;
  logic        M_RVALID, S0_RVALID, S1_RVALID;
  logic        S0_RREADY, S1_RREADY, M_RREADY;
  logic        GRANT, PROTO_ERR;

  int checkCount = 0;
  int failCount  = 0;

  axi4_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S0_ARADDR(S0_ARADDR), .S0_ARLEN(S0_ARLEN), .S0_ARID(S0_ARID),
    .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY),
    .S0_RDATA(S0_RDATA), .S0_RID(S0_RID), .S0_RRESP(S0_RRESP),
    .S0_RLAST(S0_RLAST), .S0_RVALID(S0_RVALID), .S0_RREADY(S0_RREADY),
    .S1_ARADDR(S1_ARADDR), .S1_ARLEN(S1_ARLEN), .S1_ARID(S1_ARID),
    .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY),
    .S1_RDATA(S1_RDATA), .S1_RID(S1_RID), .S1_RRESP(S1_RRESP),
    .S1_RLAST(S1_RLAST), .S1_RVALID(S1_RVALID), .S1_RREADY(S1_RREADY),
    .M_ARADDR(M_ARADDR), .M_ARLEN(M_ARLEN), .M_ARID(M_ARID),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RID(M_RID), .M_RRESP(M_RRESP),
    .M_RLAST(M_RLAST), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .GRANT(GRANT), .PROTO_ERR(PROTO_ERR)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One AR arbitration: handshake cycle in IDLE, then the registered request in ADDR.
  // M_RVALID is driven high with junk to show the R path stays closed outside DATA.
  task automatic requestAr(input logic v0, input logic v1, input logic expWin,
                           input logic [31:0] expAddr, input logic [7:0] expLen,
                           input logic [3:0] expId);
    @(negedge ACLK);
    S0_ARVALID = v0;
    S1_ARVALID = v1;
    M_RVALID   = 1'b1;
    M_RLAST    = 1'b1;
    #1;
    checkOutput("arReady0", S0_ARREADY, !expWin);
    checkOutput("arReady1", S1_ARREADY, expWin);
    checkOutput("mArValidIdle", M_ARVALID, 1'b0);
    checkOutput("rValidIdle", {S0_RVALID, S1_RVALID, M_RREADY}, 3'b000);
    @(negedge ACLK);
    if (expWin) S1_ARVALID = 1'b0;
    else S0_ARVALID = 1'b0;
    #1;
    checkOutput("mArValid", M_ARVALID, 1'b1);
    checkOutput("mArAddr", M_ARADDR, expAddr);
    checkOutput("mArLen", M_ARLEN, expLen);
    checkOutput("mArId", M_ARID, expId);
    checkOutput("grant", GRANT, expWin);
    checkOutput("arReadyAddr", {S0_ARREADY, S1_ARREADY}, 2'b00);
    checkOutput("rValidAddr", {S0_RVALID, S1_RVALID, M_RREADY}, 3'b000);
  endtask

  // Drives n always-accepted beats with RLAST on the final one.
  task automatic dataBeats(input logic sel, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      M_RVALID = 1'b1;
      M_RDATA  = base + 32'(i);
      M_RLAST  = (i == n - 1);
      #1;
      checkOutput("rValidSel", sel ? S1_RVALID : S0_RVALID, 1'b1);
      checkOutput("rValidOther", sel ? S0_RVALID : S1_RVALID, 1'b0);
      checkOutput("rData", sel ? S1_RDATA : S0_RDATA, base + 32'(i));
      checkOutput("rLast", sel ? S1_RLAST : S0_RLAST, (i == n - 1));
      checkOutput("mRReady", M_RREADY, 1'b1);
    end
  endtask

  initial begin
    ARESETN = 1'b0;
    S0_ARADDR = '0; S0_ARLEN = '0; S0_ARID = '0; S0_ARVALID = 1'b0;
    S1_ARADDR = '0; S1_ARLEN = '0; S1_ARID = '0; S1_ARVALID = 1'b0;
    S0_RREADY = 1'b1; S1_RREADY = 1'b1;
    M_ARREADY = 1'b1;
    M_RDATA = '0; M_RID = '0; M_RRESP = '0; M_RLAST = 1'b0; M_RVALID = 1'b0;

    repeat (2) @(negedge ACLK);
    #1;
    checkOutput("rstGrant", GRANT, 1'b0);
    checkOutput("rstProtoErr", PROTO_ERR, 1'b0);
    checkOutput("rstMArValid", M_ARVALID, 1'b0);
    checkOutput("rstMArAddr", M_ARADDR, 32'h0);
    checkOutput("rstRPath", {S0_RVALID, S1_RVALID, M_RREADY}, 3'b000);
    @(negedge ACLK);
    ARESETN = 1'b1;

    $display("[TB] tie after reset, 4-beat bursts");
    S0_ARADDR = 32'h1000; S0_ARLEN = 8'd3; S0_ARID = 4'h1;
    S1_ARADDR = 32'h2000; S1_ARLEN = 8'd3; S1_ARID = 4'h2;
    requestAr(1'b1, 1'b1, 1'b0, 32'h1000, 8'd3, 4'h1);
    dataBeats(1'b0, 4, 32'hA000);
    requestAr(1'b0, 1'b1, 1'b1, 32'h2000, 8'd3, 4'h2);
    dataBeats(1'b1, 4, 32'hB000);

    $display("[TB] S0 back-to-back single beats");
    for (int k = 0; k < 3; k++) begin
      S0_ARADDR = 32'h3000 + 32'(k * 16); S0_ARLEN = 8'd0; S0_ARID = 4'(k);
      requestAr(1'b1, 1'b0, 1'b0, 32'h3000 + 32'(k * 16), 8'd0, 4'(k));
      dataBeats(1'b0, 1, 32'hC000 + 32'(k));
    end

    $display("[TB] AR stall with competing S1 request");
    M_ARREADY = 1'b0;
    S0_ARADDR = 32'h4000; S0_ARLEN = 8'd0; S0_ARID = 4'h5;
    requestAr(1'b1, 1'b0, 1'b0, 32'h4000, 8'd0, 4'h5);
    S1_ARADDR = 32'h5000; S1_ARLEN = 8'd1; S1_ARID = 4'h6;
    S1_ARVALID = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge ACLK);
      if (k == 4) M_ARREADY = 1'b1;
      #1;
      checkOutput("stallArValid", M_ARVALID, 1'b1);
      checkOutput("stallArAddr", M_ARADDR, 32'h4000);
      checkOutput("stallArLen", M_ARLEN, 8'd0);
      checkOutput("stallArId", M_ARID, 4'h5);
      checkOutput("stallS1Ready", S1_ARREADY, 1'b0);
    end
    dataBeats(1'b0, 1, 32'hD000);
    requestAr(1'b0, 1'b1, 1'b1, 32'h5000, 8'd1, 4'h6);

    $display("[TB] S1_RREADY toggling");
    @(negedge ACLK);
    M_RVALID = 1'b1; M_RDATA = 32'hE0; M_RLAST = 1'b0; S1_RREADY = 1'b0;
    #1;
    checkOutput("togReady0", M_RREADY, 1'b0);
    checkOutput("togValid0", {S1_RVALID, S0_RVALID}, 2'b10);
    @(negedge ACLK);
    S1_RREADY = 1'b1;
    #1;
    checkOutput("togReady1", M_RREADY, 1'b1);
    checkOutput("togData1", S1_RDATA, 32'hE0);
    checkOutput("togS0Valid1", S0_RVALID, 1'b0);
    @(negedge ACLK);
    M_RDATA = 32'hE1; M_RLAST = 1'b1; S1_RREADY = 1'b0;
    #1;
    checkOutput("togReady2", M_RREADY, 1'b0);
    checkOutput("togValid2", {S1_RVALID, S0_RVALID}, 2'b10);
    checkOutput("togLast2", S1_RLAST, 1'b1);
    @(negedge ACLK);
    S1_RREADY = 1'b1;
    #1;
    checkOutput("togReady3", M_RREADY, 1'b1);
    checkOutput("togS0Valid3", S0_RVALID, 1'b0);

    $display("[TB] early RLAST");
    S0_ARADDR = 32'h6000; S0_ARLEN = 8'd1; S0_ARID = 4'h7;
    requestAr(1'b1, 1'b0, 1'b0, 32'h6000, 8'd1, 4'h7);
    @(negedge ACLK);
    M_RVALID = 1'b1; M_RDATA = 32'hF0; M_RLAST = 1'b1;
    #1;
    checkOutput("protoErrClean", PROTO_ERR, 1'b0);
    checkOutput("earlyValid", S0_RVALID, 1'b1);
    checkOutput("earlyLast", S0_RLAST, 1'b1);
    S0_ARADDR = 32'h6100; S0_ARLEN = 8'd0; S0_ARID = 4'h8;
    requestAr(1'b1, 1'b0, 1'b0, 32'h6100, 8'd0, 4'h8);
    checkOutput("protoErrSet", PROTO_ERR, 1'b1);
    dataBeats(1'b0, 1, 32'hF100);
    @(negedge ACLK);
    M_RVALID = 1'b0; M_RLAST = 1'b0;
    #1;
    checkOutput("protoErrSticky", PROTO_ERR, 1'b1);

    $display("[TB] reset in DATA");
    S1_ARADDR = 32'h7000; S1_ARLEN = 8'd3; S1_ARID = 4'h9;
    requestAr(1'b0, 1'b1, 1'b1, 32'h7000, 8'd3, 4'h9);
    @(negedge ACLK);
    M_RVALID = 1'b1; M_RLAST = 1'b0; M_RDATA = 32'h1234;
    #1;
    checkOutput("preRstValid", S1_RVALID, 1'b1);
    @(negedge ACLK);
    ARESETN = 1'b0;
    S0_ARVALID = 1'b1; S1_ARVALID = 1'b1;
    #1;
    checkOutput("inRstHandshakes",
                {S0_RVALID, S1_RVALID, M_RREADY, M_ARVALID, S0_ARREADY, S1_ARREADY}, 6'b0);
    checkOutput("inRstGrant", GRANT, 1'b0);
    checkOutput("inRstProtoErr", PROTO_ERR, 1'b0);
    checkOutput("inRstArAddr", M_ARADDR, 32'h0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    S0_ARVALID = 1'b0; S1_ARVALID = 1'b0; M_RVALID = 1'b0;
    S0_ARADDR = 32'h8000; S0_ARLEN = 8'd0; S0_ARID = 4'hA;
    S1_ARADDR = 32'h9000; S1_ARLEN = 8'd0; S1_ARID = 4'hB;
    requestAr(1'b1, 1'b1, 1'b0, 32'h8000, 8'd0, 4'hA);
    S1_ARVALID = 1'b0;

    $display("[TB] missing RLAST on final counted beat");
    @(negedge ACLK);
    M_RVALID = 1'b1; M_RLAST = 1'b0; M_RDATA = 32'h55;
    #1;
    checkOutput("noLastErr0", PROTO_ERR, 1'b0);
    checkOutput("noLastValid0", S0_RVALID, 1'b1);
    @(negedge ACLK);
    M_RLAST = 1'b1; M_RDATA = 32'h56;
    #1;
    checkOutput("noLastErr1", PROTO_ERR, 1'b1);
    checkOutput("noLastValid1", S0_RVALID, 1'b1);
    @(negedge ACLK);
    #1;
    checkOutput("noLastIdle", {S0_RVALID, S1_RVALID, M_RREADY}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
